// File: rtl/shift_issue_if.sv
// Bundle of the upstream op, shifter command/status and writeback signals.
// The issue block sits on the slave modport and its environment sits on the master modport.
interface shift_issue_if #(
    parameter int RD_W = 5
);
    logic            op_valid;
    logic            op_ready;
    logic [1:0]      op_kind;
    logic [31:0]     op_a;
    logic [31:0]     op_b;
    logic [RD_W-1:0] op_rd;

    logic            sh_kick;
    logic            sh_lshift;
    logic            sh_unsigned;
    logic [31:0]     sh_a;
    logic [31:0]     sh_b;
    logic            sh_ready;
    logic            sh_done;
    logic [31:0]     sh_q;

    logic            wb_valid;
    logic            wb_ready;
    logic [RD_W-1:0] wb_rd;
    logic [31:0]     wb_data;
    logic            wb_err;

    logic            busy;

    modport master (
        output op_valid, op_kind, op_a, op_b, op_rd,
        input  op_ready,
        input  sh_kick, sh_lshift, sh_unsigned, sh_a, sh_b,
        output sh_ready, sh_done, sh_q,
        input  wb_valid, wb_rd, wb_data, wb_err,
        output wb_ready,
        input  busy
    );

    modport slave (
        input  op_valid, op_kind, op_a, op_b, op_rd,
        output op_ready,
        output sh_kick, sh_lshift, sh_unsigned, sh_a, sh_b,
        input  sh_ready, sh_done, sh_q,
        output wb_valid, wb_rd, wb_data, wb_err,
        input  wb_ready,
        output busy
    );
endinterface

// File: rtl/shift_issue.sv
// Issues shift ops to an external iterative shifter and returns the result on a writeback port.
// Zero-amount and illegal ops bypass the shifter and go straight to writeback.
module shift_issue #(
    parameter int RD_W = 5
) (
    input  logic          clk,
    input  logic          reset,
    shift_issue_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KICK = 2'd1,
        WAIT = 2'd2,
        WB   = 2'd3
    } state_e;

    localparam logic [1:0] KIND_SLL = 2'b00;
    localparam logic [1:0] KIND_SRL = 2'b01;
    localparam logic [1:0] KIND_ILL = 2'b11;

    state_e          state_q, state_d;
    logic [31:0]     a_q, a_d;
    logic [4:0]      shamt_q, shamt_d;
    logic [1:0]      kind_q, kind_d;
    logic [RD_W-1:0] rd_q, rd_d;
    logic [31:0]     wb_data_q, wb_data_d;
    logic            wb_err_q, wb_err_d;
    logic            unused_op_b_s;

    // Only the low five bits of op_b form the shift amount.
    assign unused_op_b_s = ^bus.op_b[31:5];

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            a_q       <= 32'd0;
            shamt_q   <= 5'd0;
            kind_q    <= 2'b00;
            rd_q      <= '0;
            wb_data_q <= 32'd0;
            wb_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            shamt_q   <= shamt_d;
            kind_q    <= kind_d;
            rd_q      <= rd_d;
            wb_data_q <= wb_data_d;
            wb_err_q  <= wb_err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.op_valid) begin
                    if ((bus.op_kind == KIND_ILL) || (bus.op_b[4:0] == 5'd0)) begin
                        state_d = WB;
                    end else begin
                        state_d = KICK;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            KICK: begin
                if (bus.sh_ready) begin
                    state_d = WAIT;
                end else begin
                    state_d = KICK;
                end
            end
            // sh_done was cleared by the shifter on the kick edge, so it is fresh here.
            WAIT: begin
                if (bus.sh_done) begin
                    state_d = WB;
                end else begin
                    state_d = WAIT;
                end
            end
            WB: begin
                if (bus.wb_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = WB;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture on accept and writeback payload selection.
    always_comb begin
        a_d       = a_q;
        shamt_d   = shamt_q;
        kind_d    = kind_q;
        rd_d      = rd_q;
        wb_data_d = wb_data_q;
        wb_err_d  = wb_err_q;
        case (state_q)
            IDLE: begin
                if (bus.op_valid) begin
                    a_d     = bus.op_a;
                    shamt_d = bus.op_b[4:0];
                    kind_d  = bus.op_kind;
                    rd_d    = bus.op_rd;
                    if (bus.op_kind == KIND_ILL) begin
                        wb_data_d = 32'd0;
                        wb_err_d  = 1'b1;
                    end else if (bus.op_b[4:0] == 5'd0) begin
                        wb_data_d = bus.op_a;
                        wb_err_d  = 1'b0;
                    end else begin
                        wb_data_d = wb_data_q;
                    end
                end else begin
                    a_d = a_q;
                end
            end
            WAIT: begin
                if (bus.sh_done) begin
                    wb_data_d = bus.sh_q;
                    wb_err_d  = 1'b0;
                end else begin
                    wb_data_d = wb_data_q;
                end
            end
            default: begin
                wb_data_d = wb_data_q;
            end
        endcase
    end

    // State-decoded handshake and control outputs.
    always_comb begin
        bus.op_ready = 1'b0;
        bus.busy     = 1'b1;
        bus.sh_kick  = 1'b0;
        bus.wb_valid = 1'b0;
        case (state_q)
            IDLE: begin
                bus.op_ready = 1'b1;
                bus.busy     = 1'b0;
            end
            KICK:    bus.sh_kick  = bus.sh_ready;
            WAIT:    bus.sh_kick  = 1'b0;
            WB:      bus.wb_valid = 1'b1;
            default: bus.busy     = 1'b1;
        endcase
    end

    assign bus.sh_a        = a_q;
    assign bus.sh_b        = {27'd0, shamt_q};
    assign bus.sh_lshift   = (kind_q == KIND_SLL);
    assign bus.sh_unsigned = (kind_q == KIND_SRL);
    assign bus.wb_rd       = rd_q;
    assign bus.wb_data     = wb_data_q;
    assign bus.wb_err      = wb_err_q;
endmodule

// File: tb/tb_shift_issue.sv
// Directed bench for shift_issue with a behavioural iterative shifter alongside.
module tb_shift_issue;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int unsigned cyc = 0;
    int unsigned kick_cnt = 0;
    int unsigned t0 = 0;
    int unsigned k0 = 0;

    shift_issue_if #(.RD_W(5)) bus ();

    shift_issue #(.RD_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Iterative shifter: first bit on the kick edge, one bit per edge after, sticky done.
    logic [31:0] m_q    = 32'd0;
    logic [4:0]  m_cnt  = 5'd0;
    logic        m_done = 1'b1;
    logic        m_lsh  = 1'b0;
    logic        m_uns  = 1'b0;

    function automatic logic [31:0] shift1(input logic [31:0] v, input logic lsh, input logic uns);
        if (lsh)      return {v[30:0], 1'b0};
        else if (uns) return {1'b0, v[31:1]};
        else          return {v[31], v[31:1]};
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.sh_kick) begin
            kick_cnt <= kick_cnt + 1;
            m_lsh    <= bus.sh_lshift;
            m_uns    <= bus.sh_unsigned;
            m_q      <= shift1(bus.sh_a, bus.sh_lshift, bus.sh_unsigned);
            m_cnt    <= bus.sh_b[4:0] - 5'd1;
            m_done   <= (bus.sh_b[4:0] == 5'd1);
        end else if (m_cnt != 5'd0) begin
            m_q    <= shift1(m_q, m_lsh, m_uns);
            m_cnt  <= m_cnt - 5'd1;
            m_done <= (m_cnt == 5'd1);
        end
    end

    assign bus.sh_done = m_done;
    assign bus.sh_q    = m_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents one op for a single cycle; t0 marks the cycle before the accept edge.
    task automatic issue(input logic [1:0] k, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        @(negedge clk);
        chk("op_ready_before_accept", {31'd0, bus.op_ready}, 32'd1);
        k0           = kick_cnt;
        t0           = cyc;
        bus.op_valid = 1'b1;
        bus.op_kind  = k;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.op_rd    = rd;
        @(negedge clk);
        bus.op_valid = 1'b0;
    endtask

    task automatic wait_wb(input int budget);
        int n = 0;
        while (!bus.wb_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wb_valid_within_budget", {31'd0, bus.wb_valid}, 32'd1);
    endtask

    task automatic retire();
        bus.wb_ready = 1'b1;
        @(negedge clk);
        bus.wb_ready = 1'b0;
        chk("wb_valid_after_handshake", {31'd0, bus.wb_valid}, 32'd0);
        chk("op_ready_after_handshake", {31'd0, bus.op_ready}, 32'd1);
    endtask

    initial begin
        int seen;
        bus.op_valid = 1'b0;
        bus.op_kind  = 2'b00;
        bus.op_a     = 32'd0;
        bus.op_b     = 32'd0;
        bus.op_rd    = 5'd0;
        bus.sh_ready = 1'b1;
        bus.wb_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        chk("rst_wb_err",   {31'd0, bus.wb_err},   32'd0);
        chk("rst_wb_data",  bus.wb_data,           32'd0);
        chk("rst_wb_rd",    {27'd0, bus.wb_rd},    32'd0);
        chk("rst_sh_kick",  {31'd0, bus.sh_kick},  32'd0);
        chk("rst_busy",     {31'd0, bus.busy},     32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_op_ready", {31'd0, bus.op_ready}, 32'd1);

        // SLL 1 by 4
        issue(2'b00, 32'h0000_0001, 32'd4, 5'd7);
        chk("sll_busy",     {31'd0, bus.busy},      32'd1);
        chk("sll_op_ready", {31'd0, bus.op_ready},  32'd0);
        chk("sll_kick",     {31'd0, bus.sh_kick},   32'd1);
        chk("sll_lshift",   {31'd0, bus.sh_lshift}, 32'd1);
        chk("sll_sh_a",     bus.sh_a,               32'h0000_0001);
        chk("sll_sh_b",     bus.sh_b,               32'd4);
        wait_wb(50);
        chk("sll_latency",  cyc - t0,               32'd6);
        chk("sll_data",     bus.wb_data,            32'h0000_0010);
        chk("sll_err",      {31'd0, bus.wb_err},    32'd0);
        chk("sll_rd",       {27'd0, bus.wb_rd},     32'd7);
        chk("sll_kicks",    kick_cnt - k0,          32'd1);
        retire();

        // SRA 0x80000000 by 31
        issue(2'b10, 32'h8000_0000, 32'd31, 5'd1);
        chk("sra_lshift",   {31'd0, bus.sh_lshift},   32'd0);
        chk("sra_unsigned", {31'd0, bus.sh_unsigned}, 32'd0);
        wait_wb(60);
        chk("sra_latency",  cyc - t0,                 32'd33);
        chk("sra_data",     bus.wb_data,              32'hFFFF_FFFF);
        retire();

        // SRL 0x80000000 by 31, upper amount bits set and ignored
        issue(2'b01, 32'h8000_0000, 32'h0000_00FF, 5'd2);
        chk("srl_unsigned", {31'd0, bus.sh_unsigned}, 32'd1);
        chk("srl_sh_b",     bus.sh_b,                 32'd31);
        wait_wb(60);
        chk("srl_data",     bus.wb_data,              32'h0000_0001);
        chk("srl_rd",       {27'd0, bus.wb_rd},       32'd2);
        retire();

        // SRL by 32 -> zero amount bypass
        issue(2'b01, 32'h1234_5678, 32'd32, 5'd3);
        wait_wb(5);
        chk("zero_latency", cyc - t0,              32'd1);
        chk("zero_data",    bus.wb_data,           32'h1234_5678);
        chk("zero_err",     {31'd0, bus.wb_err},   32'd0);
        chk("zero_kicks",   kick_cnt - k0,         32'd0);
        retire();

        // Illegal kind with writeback back-pressure and an ignored op
        issue(2'b11, 32'hFFFF_FFFF, 32'd4, 5'd4);
        wait_wb(5);
        chk("ill_latency",  cyc - t0,              32'd1);
        chk("ill_err",      {31'd0, bus.wb_err},   32'd1);
        chk("ill_data",     bus.wb_data,           32'd0);
        bus.op_valid = 1'b1;
        bus.op_kind  = 2'b00;
        bus.op_a     = 32'h0000_00AA;
        bus.op_b     = 32'd1;
        bus.op_rd    = 5'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ill_hold_valid", {31'd0, bus.wb_valid}, 32'd1);
            chk("ill_hold_data",  bus.wb_data,           32'd0);
            chk("ill_hold_err",   {31'd0, bus.wb_err},   32'd1);
            chk("ill_hold_rd",    {27'd0, bus.wb_rd},    32'd4);
            chk("ill_op_ready",   {31'd0, bus.op_ready}, 32'd0);
        end
        bus.op_valid = 1'b0;
        chk("ill_kicks", kick_cnt - k0, 32'd0);
        retire();
        chk("ill_no_accept_busy", {31'd0, bus.busy}, 32'd0);

        // Shifter not ready for 3 cycles while a stale done is high
        bus.sh_ready = 1'b0;
        issue(2'b00, 32'h0000_0003, 32'd2, 5'd6);
        chk("stall_kick0", {31'd0, bus.sh_kick}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("stall_kick_low", {31'd0, bus.sh_kick}, 32'd0);
            chk("stall_no_wb",    {31'd0, bus.wb_valid}, 32'd0);
        end
        bus.sh_ready = 1'b1;
        #1;
        chk("stall_kick_high", {31'd0, bus.sh_kick}, 32'd1);
        wait_wb(20);
        chk("stall_data",  bus.wb_data,   32'h0000_000C);
        chk("stall_kicks", kick_cnt - k0, 32'd1);
        retire();

        // Reset pulse while waiting on the shifter
        issue(2'b01, 32'h0000_00F0, 32'd8, 5'd8);
        repeat (2) @(negedge clk);
        chk("abort_in_wait", {31'd0, bus.busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        chk("abort_busy",     {31'd0, bus.busy},     32'd0);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.wb_valid) seen++;
        end
        chk("abort_no_writeback", seen, 32'd0);
        bus.sh_ready = 1'b0;
        issue(2'b00, 32'h0000_0005, 32'd2, 5'd9);
        chk("post_abort_kick_low", {31'd0, bus.sh_kick}, 32'd0);
        bus.sh_ready = 1'b1;
        #1;
        chk("post_abort_kick_high", {31'd0, bus.sh_kick}, 32'd1);
        wait_wb(20);
        chk("post_abort_data", bus.wb_data,        32'h0000_0014);
        chk("post_abort_rd",   {27'd0, bus.wb_rd}, 32'd9);
        retire();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
